// File: rtl/output_port_allocator_pkg.sv
// Shared types and helpers for the output port allocator.
// Optional build macro: ALLOC_FAST_REGRANT_EN (see output_port_allocator.sv).
package output_port_allocator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alloc_state_e;

  // Index width for a vector of n requesters (at least one bit).
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment an index modulo n.
  function automatic int wrap_inc(int i, int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/output_port_allocator_if.sv
// VC-side and link-side signals of one output port allocator.
// data_i packs VC k at bits [k*FLIT_W +: FLIT_W].
interface output_port_allocator_if #(
  parameter int IN_N        = 5,
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2
);
  localparam int FLIT_W = FLIT_DATA_W + FLIT_ID_W;

  logic [IN_N-1:0]             req_i;
  logic [IN_N-1:0]             is_tail_i;
  logic [IN_N-1:0][FLIT_W-1:0] data_i;
  logic [IN_N-1:0]             vld_i;
  logic [IN_N-1:0]             granted_o;
  logic [IN_N-1:0]             rdy_o;
  logic [FLIT_W-1:0]           data_o;
  logic                        vld_o;
  logic                        rdy_i;

  modport slave (
    input  req_i, is_tail_i, data_i, vld_i, rdy_i,
    output granted_o, rdy_o, data_o, vld_o
  );

  modport master (
    output req_i, is_tail_i, data_i, vld_i, rdy_i,
    input  granted_o, rdy_o, data_o, vld_o
  );
endinterface

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping modulo IN_N.
module rr_arbiter #(
  parameter int IN_N  = 5,
  parameter int IDX_W = 3
) (
  input  logic [IN_N-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IN_N-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] k;

  // Scan farthest-first so the closest requester to ptr is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int d = IN_N - 1; d >= 0; d--) begin
      k = IDX_W'((int'(ptr) + d) % IN_N);
      if (req[k]) begin
        gnt = IN_N'(1) << k;
        idx = k;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output port allocator and switch mux. One VC owns the output
// from grant until its tail flit transfers; the link sees the owner's flit
// stream and backpressure is steered only to the owner.
// ALLOC_FAST_REGRANT_EN: re-arbitrate on the tail cycle (released owner
// masked) so a waiting VC is granted with no IDLE bubble.
module output_port_allocator
  import output_port_allocator_pkg::*;
#(
  parameter int IN_N        = 5,
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output_port_allocator_if.slave  port
);
  localparam int IDX_W = idx_w(IN_N);

  alloc_state_e     state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IN_N-1:0]  granted_q, granted_d;
  logic [IDX_W-1:0] nxt_ptr;
  logic             busy, xfer, tail_xfer;

  logic [IN_N-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  assign busy      = (state_q == ST_BUSY);
  assign xfer      = busy & port.vld_i[owner_q] & port.rdy_i;
  assign tail_xfer = xfer & port.is_tail_i[owner_q];
  assign nxt_ptr   = IDX_W'(wrap_inc(int'(owner_q), IN_N));

  rr_arbiter #(.IN_N(IN_N), .IDX_W(IDX_W)) u_arb (
    .req (port.req_i),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef ALLOC_FAST_REGRANT_EN
  logic [IN_N-1:0]  fast_gnt;
  logic [IDX_W-1:0] fast_idx;
  logic             fast_any;

  rr_arbiter #(.IN_N(IN_N), .IDX_W(IDX_W)) u_fast_arb (
    .req (port.req_i & ~(IN_N'(1) << owner_q)),
    .ptr (nxt_ptr),
    .gnt (fast_gnt),
    .idx (fast_idx),
    .any (fast_any)
  );
`endif

  // State, owner, pointer and registered grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      granted_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      granted_q <= granted_d;
    end
  end

  // Grant on request from IDLE; release (or hand over) on tail transfer.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    granted_d = granted_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d   = ST_BUSY;
          owner_d   = arb_idx;
          granted_d = arb_gnt;
        end
      end
      ST_BUSY: begin
        if (tail_xfer) begin
          rr_ptr_d = nxt_ptr;
`ifdef ALLOC_FAST_REGRANT_EN
          if (fast_any) begin
            owner_d   = fast_idx;
            granted_d = fast_gnt;
          end else begin
            state_d   = ST_IDLE;
            granted_d = '0;
          end
`else
          state_d   = ST_IDLE;
          granted_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign port.granted_o = granted_q;
  assign port.vld_o     = busy & port.vld_i[owner_q];
  assign port.data_o    = busy ? port.data_i[owner_q] : '0;
  assign port.rdy_o     = busy ? (IN_N'(port.rdy_i) << owner_q) : '0;

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: directed scenarios then
// random traffic, compared each cycle against a packet-level model.
module tb_output_port_allocator;
  localparam int N  = 5;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int FW = DW + IW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_port_allocator_if #(.IN_N(N), .FLIT_DATA_W(DW), .FLIT_ID_W(IW)) bus ();

  output_port_allocator #(.IN_N(N), .FLIT_DATA_W(DW), .FLIT_ID_W(IW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .port   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: which VC (if any) owns the link, and who has top priority.
  bit m_busy;
  int m_own;
  int m_rr;

  function automatic int pick(logic [N-1:0] req, int start);
    for (int d = 0; d < N; d++)
      if (req[(start + d) % N]) return (start + d) % N;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    logic [N-1:0]  e_gnt, e_rdy;
    logic          e_vld;
    logic [FW-1:0] e_data;
    e_gnt = '0; e_rdy = '0; e_vld = 1'b0; e_data = '0;
    if (m_busy) begin
      e_gnt[m_own] = 1'b1;
      e_rdy[m_own] = bus.rdy_i;
      e_vld        = bus.vld_i[m_own];
      e_data       = bus.data_i[m_own];
    end
    chk("granted_o", 32'(bus.granted_o), 32'(e_gnt));
    chk("rdy_o",     32'(bus.rdy_o),     32'(e_rdy));
    chk("vld_o",     32'(bus.vld_o),     32'(e_vld));
    chk("data_o",    32'(bus.data_o),    32'(e_data));
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) return;
    if (m_busy) begin
      if (bus.vld_i[m_own] && bus.rdy_i && bus.is_tail_i[m_own]) begin
        m_rr = (m_own + 1) % N;
`ifdef ALLOC_FAST_REGRANT_EN
        begin
          logic [N-1:0] others;
          others = bus.req_i;
          others[m_own] = 1'b0;
          w = pick(others, m_rr);
        end
        if (w >= 0) m_own = w;
        else m_busy = 1'b0;
`else
        m_busy = 1'b0;
`endif
      end
    end else begin
      w = pick(bus.req_i, m_rr);
      if (w >= 0) begin
        m_own  = w;
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = 0;
    m_rr   = 0;
  endtask

  // Inputs change at negedge; outputs checked 1 ns later; model steps at posedge.
  task automatic cycle();
    #1 check_outs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(logic [N-1:0] req, logic [N-1:0] tail,
                       logic [N-1:0] vld, logic rdy);
    bus.req_i     = req;
    bus.is_tail_i = tail;
    bus.vld_i     = vld;
    bus.rdy_i     = rdy;
    for (int k = 0; k < N; k++) bus.data_i[k] = FW'($urandom);
  endtask

  initial begin
    model_reset();
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
    #2 check_outs();
    chk("reset_granted_zero", 32'(bus.granted_o), 32'd0);
    chk("reset_vld_zero",     32'(bus.vld_o),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive('0, '0, '0, 1'b1);
    cycle();

    // Single-flit packet on VC2, then a full tie must go to VC3.
    drive(5'b00100, 5'b00100, 5'b00100, 1'b1);
    cycle();
    chk("vc2_granted", 32'(bus.granted_o), 32'h04);
    cycle();
    drive('0, '0, '0, 1'b1);
    cycle();
    drive(5'b11111, '0, 5'b11111, 1'b1);
    #1 chk("idle_vld", 32'(bus.vld_o), 32'd0);
    cycle();
    chk("tie_after_vc2", 32'(bus.granted_o), 32'h08);
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
    cycle();
    drive('0, '0, '0, 1'b1);
    cycle();

    // VC3 owner: backpressure for 4 cycles, data held, then drops req.
    drive(5'b01000, '0, 5'b01000, 1'b1);
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      bus.rdy_i = 1'b0;
      bus.req_i = 5'b00001;
      cycle();
    end
    drive(5'b00001, '0, 5'b01001, 1'b1);
    cycle();
    drive(5'b00001, 5'b01000, 5'b01001, 1'b1);
    cycle();
    drive(5'b00001, '0, 5'b00001, 1'b1);
    cycle();
    cycle();

    // Reset in the middle of a packet.
    drive(5'b00010, '0, 5'b00010, 1'b1);
    cycle();
    cycle();
    rst_n = 1'b0;
    model_reset();
    #1 check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] tail;
      for (int k = 0; k < N; k++) tail[k] = ($urandom_range(0, 3) == 0);
      drive(N'($urandom), tail, N'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1 check_outs();
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
